// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: read-side stage behind a synchronous FIFO with a
// one-cycle registered read. Pops words, buffers them in a 2-entry skid
// buffer and re-presents them as a valid/ready stream framed into
// BURST_LEN-word bursts (m_last on the final word of each burst).
// Optional feature macro: STREAM_PARITY_EN adds m_parity (even parity of
// m_data), stored alongside each buffered word.
module fifo_stream_drain #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
`ifdef STREAM_PARITY_EN
  output logic              m_parity,
`endif
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  // Even parity of a data word.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Registered state
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
`ifdef STREAM_PARITY_EN
  logic              par_q [2];
  logic              par_d [2];
`endif

  // Combinational helpers
  logic       pop_s;
  logic [2:0] fill_s;
  logic [1:0] occ_mid_s;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf_q[0];
  assign m_last   = (beat_q == BEAT_LAST) && m_valid;
  assign word_cnt = cnt_q;
`ifdef STREAM_PARITY_EN
  assign m_parity = par_q[0] && m_valid;
`endif

  assign pop_s  = m_valid && m_ready;
  // Words already committed to the buffer: held plus the one arriving now.
  assign fill_s = {1'b0, occ_q} + {2'b00, inflight_q};
  // Only request another word if it is guaranteed a slot when it lands.
  assign fifo_rd = !fifo_empty && !rst && (fill_s < (3'd2 + {2'b00, pop_s}));
  assign inflight_d = fifo_rd && !fifo_empty;
  assign occ_mid_s  = occ_q - {1'b0, pop_s};

  // Buffer next state: pop shifts the head out, a landing word fills the
  // first free slot behind whatever remains.
  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
`ifdef STREAM_PARITY_EN
    par_d[0] = par_q[0];
    par_d[1] = par_q[1];
`endif
    if (pop_s) begin
      buf_d[0] = buf_q[1];
`ifdef STREAM_PARITY_EN
      par_d[0] = par_q[1];
`endif
    end else begin
      buf_d[0] = buf_q[0];
    end
    if (inflight_q) begin
      if (occ_mid_s == 2'd0) begin
        buf_d[0] = fifo_data;
`ifdef STREAM_PARITY_EN
        par_d[0] = even_parity(fifo_data);
`endif
      end else begin
        buf_d[1] = fifo_data;
`ifdef STREAM_PARITY_EN
        par_d[1] = even_parity(fifo_data);
`endif
      end
    end else begin
      buf_d[1] = buf_d[1];
    end
    occ_d = occ_mid_s + {1'b0, inflight_q};
  end

  // Burst position and handed-off word counter advance on each handshake.
  always_comb begin
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (pop_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (beat_q == BEAT_LAST) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
`ifdef STREAM_PARITY_EN
      par_q[0]   <= 1'b0;
      par_q[1]   <= 1'b0;
`endif
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
`ifdef STREAM_PARITY_EN
      par_q[0]   <= par_d[0];
      par_q[1]   <= par_d[1];
`endif
    end
  end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Read-side stage directly downstream of the 32-bit synchronous FIFO.
- Pops words from the FIFO and re-presents them as a valid/ready stream, framed into fixed-length bursts with a last marker.
- Hides the FIFO's one-cycle registered read latency with a 2-entry output buffer, so the stream sustains 1 word/cycle.
- Feeds the downstream packet/transmit logic.

Parameters:
- DATA_W, 32, word width; must match the FIFO data_out width.
- BURST_LEN, 8, words per burst; legal range 1..256.
- CNT_W, 16, width of the transferred-word status counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; all flops clear immediately on assertion.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  FIFO read strobe; the FIFO pops on a rising edge with fifo_rd=1 and fifo_empty=0.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after an accepted fifo_rd.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from downstream.
- m_last  out  1  high with the final word of each BURST_LEN burst.
- word_cnt  out  CNT_W  total words handed off (m_valid && m_ready); wraps modulo 2^CNT_W.

Behaviour:
- Reset values: fifo_rd=0, m_valid=0, m_data=0, m_last=0, word_cnt=0, buffer occupancy=0, in-flight flag=0, beat index=0.
- Reset asserted mid-burst discards buffered and in-flight words; the beat index restarts at 0.
- Internal state:
  - occ: 0..2, valid words held in the output buffer.
  - inflight: 1 if fifo_rd was accepted last cycle, so data arrives this cycle.
  - beat: 0..BURST_LEN-1.
- fifo_rd (combinational): asserted when !fifo_empty && !rst && (occ + inflight - pop) < 2, where pop = m_valid && m_ready this cycle. It is never asserted while fifo_empty=1.
- inflight <= fifo_rd && !fifo_empty, registered each cycle.
- When inflight=1, fifo_data is captured into the buffer tail on that edge.
- Buffer is a 2-entry FIFO; the head drives m_data. Head-to-tail order equals FIFO pop order.
- Simultaneous capture and pop in the same cycle: occ is unchanged, the head advances, and the new word lands behind any remaining entry.
- m_valid = (occ != 0), driven from registered state.
- m_data and m_last are held stable while m_valid=1 and m_ready=0.
- m_last = (beat == BURST_LEN-1) && m_valid.
- On each handshake, beat increments and wraps to 0 after BURST_LEN-1. With BURST_LEN=1, m_last is constantly high with m_valid.
- On each handshake, word_cnt increments, wrapping at all-ones to 0.
- Latency: FIFO non-empty at edge N (occ=0) gives fifo_rd in cycle N, data captured at edge N+1, and m_valid high in cycle N+1.
- Throughput: with the FIFO non-empty and m_ready held high, one handshake per cycle, no bubbles after the first word.
- Backpressure: with m_ready=0, at most 2 words are buffered and fifo_rd stays low, including accounting for an in-flight word. No word is ever dropped or duplicated.
- FIFO going empty mid-burst: m_valid falls once the buffer drains; the beat position is retained, and the burst resumes when data returns. No partial-burst flush.

Optional Feature:
- Macro: STREAM_PARITY_EN.
- Defined: adds output port m_parity (1 bit) = XOR of m_data (even parity), stored alongside each buffered entry. It is 0 at reset and 0 whenever m_valid=0.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Reset then FIFO holding 0x1..0x8, m_ready=1 -> first m_valid one cycle after the first fifo_rd; 8 consecutive handshakes with data 0x1..0x8; m_last only on 0x8; word_cnt=8.
- m_ready=0 with 5 words in the FIFO -> exactly 2 fifo_rd pulses, m_data=first word held stable; after m_ready=1, all 5 words appear in order with no loss.
- Empty FIFO mid-burst after 3 words, refilled 10 cycles later -> m_valid=0 during the gap; m_last lands on the 5th post-refill word (beat 7).
- Async rst pulse mid-clock while occ=2 -> outputs clear before the next edge; the following burst restarts at beat 0 with word_cnt=0.
- CNT_W=4, 17 words streamed -> word_cnt wraps to 0 after 16, reads 1.
- STREAM_PARITY_EN defined, words 0x00000001 and 0x00000003 -> m_parity=1 then 0.
